// File: rtl/priority_decoder_38_seq_if.sv
// priority_decoder_38_seq_if: index-stream input and rebuilt-vector output bus
// master drives in_valid/in_idx/in_last/in_empty and out_ready
// slave drives in_ready and out_valid/out_vec/out_count/out_err
interface priority_decoder_38_seq_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_last;
    logic             in_empty;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_vec;
    logic [CNT_W-1:0] out_count;
    logic             out_err;
    modport master (
        output in_valid, in_idx, in_last, in_empty, out_ready,
        input  in_ready, out_valid, out_vec, out_count, out_err
    );
    modport slave (
        input  in_valid, in_idx, in_last, in_empty, out_ready,
        output in_ready, out_valid, out_vec, out_count, out_err
    );
endinterface

// File: rtl/priority_decoder_38_seq.sv
// priority_decoder_38_seq: rebuilds a request vector from a highest-first index stream
// clk    rising-edge clock
// rst_n  asynchronous active-low reset
// bus    slave side of priority_decoder_38_seq_if (index beats in, vector/count/err out)
module priority_decoder_38_seq #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input logic                      clk,
    input logic                      rst_n,
    priority_decoder_38_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
    state_t           state;
    logic [WIDTH-1:0] acc, onehot, nacc;
    logic [CNT_W-1:0] cnt, ncnt;
    logic [IDX_W-1:0] prev;
    logic             err, nerr, accept, first, done, dup;
    // HOLD accepts a new beat only when the held result leaves in the same cycle
    assign bus.in_ready = (state == HOLD) ? bus.out_ready : 1'b1;
    always_comb begin
        accept = bus.in_valid && bus.in_ready;
        first  = state != COLLECT;
        onehot = WIDTH'(1) << bus.in_idx;
        dup    = |(acc & onehot);
        nacc   = bus.in_empty ? (first ? '0 : acc) : (first ? onehot : acc | onehot);
        ncnt   = first ? (bus.in_empty ? '0 : CNT_W'(1)) : cnt + CNT_W'(!bus.in_empty && !dup);
        // a stream from a priority encoder must strictly descend; empty mid-frame is also malformed
        nerr   = !first && (err || bus.in_empty || bus.in_idx >= prev);
        done   = bus.in_last || (first && bus.in_empty);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            prev          <= '0;
            err           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_vec   <= '0;
            bus.out_count <= '0;
            bus.out_err   <= 1'b0;
        end else if (accept) begin
            acc <= nacc;
            cnt <= ncnt;
            err <= nerr;
            if (first || !bus.in_empty) prev <= bus.in_idx;
            bus.out_valid <= done;
            state         <= done ? HOLD : COLLECT;
            if (done) begin
                bus.out_vec   <= nacc;
                bus.out_count <= ncnt;
                bus.out_err   <= nerr;
            end
        end else if (state == HOLD && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
        end
    end
endmodule
